// File: rtl/energy_gov_pkg.sv
// ---------------------------------------------------------------------------
// energy_gov_pkg
// Shared constants and types for the energy budget governor:
//   - datapath widths (energy accumulator, budget, frequency)
//   - governor FSM state encoding
//   - window-energy saturation value and the matching clamp helper
//   - packed type describing a frequency change decision
// ---------------------------------------------------------------------------
package energy_gov_pkg;

    localparam int ENERGY_W = 64;
    localparam int BUDGET_W = 32;
    localparam int FREQ_W   = 16;

    // Governor FSM encoding (exposed directly on gov_state)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MONITOR = 2'd1;
    localparam logic [1:0] ST_REQ     = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // Window energy reported when the true delta does not fit in 32 bits
    localparam logic [BUDGET_W-1:0] ENERGY_SAT = 32'hFFFF_FFFF;

    // One frequency decision: whether to request, and the target
    typedef struct packed {
        logic              go;
        logic [FREQ_W-1:0] freq;
    } freq_req_t;

    // Clamp a 64-bit window delta into the 32-bit reporting field
    function automatic logic [BUDGET_W-1:0] sat_energy(input logic [ENERGY_W-1:0] d);
        logic [BUDGET_W-1:0] r;
        if (d[ENERGY_W-1:BUDGET_W] != '0) begin
            r = ENERGY_SAT;
        end else begin
            r = d[BUDGET_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/energy_window_timer.sv
// ---------------------------------------------------------------------------
// energy_window_timer
// Evaluation window counter for the energy governor.
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : monitoring enable
//   start      : high on the first cycle of an enable rise (previous enable=0)
//   window_end : high on the last cycle of each window (count = WINDOW_CYCLES-1)
// The counter holds 0 while disabled and restarts from 0 on an enable rise,
// so the rise cycle itself is not part of the first window.
// ---------------------------------------------------------------------------
module energy_window_timer #(
    parameter int WINDOW_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic window_end,
    output logic start
);

    localparam int            CW   = $clog2(WINDOW_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          enable_prev_reg;

    assign start      = enable & ~enable_prev_reg;
    // Gating on enable_prev keeps a rise cycle from ever being a window end
    assign window_end = enable & enable_prev_reg & (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (!enable || start) begin
            count_next = '0;
        end else if (count_reg == LAST) begin
            count_next = '0;
        end else begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg       <= '0;
            enable_prev_reg <= 1'b0;
        end else begin
            count_reg       <= count_next;
            enable_prev_reg <= enable;
        end
    end

endmodule

// File: rtl/energy_budget_governor.sv
// ---------------------------------------------------------------------------
// energy_budget_governor
// Measures energy consumed per fixed window from a free-running cumulative
// energy counter and issues DVFS step requests over a valid/ready handshake.
//   clk              : clock, rising edge
//   reset_n          : asynchronous active-low reset
//   enable           : monitoring enable; 0 forces IDLE
//   total_energy_pj  : cumulative energy, modulo 2^64
//   budget_pj        : allowed energy per window
//   current_freq_mhz : present operating frequency
//   req_valid        : DVFS request pending (exactly while in REQ)
//   req_ready        : DVFS request accepted
//   req_freq_mhz     : requested frequency (stable while req_valid)
//   window_energy_pj : last window's energy, saturated to 32 bits
//   over_budget      : last window exceeded the budget
//   gov_state        : FSM state (IDLE/MONITOR/REQ/HOLD)
// ---------------------------------------------------------------------------
module energy_budget_governor
    import energy_gov_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1024,
    parameter int FREQ_STEP_MHZ = 100,
    parameter int FREQ_MIN_MHZ  = 100,
    parameter int FREQ_MAX_MHZ  = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [ENERGY_W-1:0] total_energy_pj,
    input  logic [BUDGET_W-1:0] budget_pj,
    input  logic [FREQ_W-1:0]   current_freq_mhz,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [FREQ_W-1:0]   req_freq_mhz,
    output logic [BUDGET_W-1:0] window_energy_pj,
    output logic                over_budget,
    output logic [1:0]          gov_state
);

    // Step arithmetic is done one bit wider than the frequency so that
    // current+step cannot wrap before the clamp.
    localparam logic [FREQ_W:0] STEP17 = (FREQ_W+1)'(FREQ_STEP_MHZ);
    localparam logic [FREQ_W:0] MIN17  = (FREQ_W+1)'(FREQ_MIN_MHZ);
    localparam logic [FREQ_W:0] MAX17  = (FREQ_W+1)'(FREQ_MAX_MHZ);

    logic window_end;
    logic start;

    energy_window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .window_end (window_end),
        .start      (start)
    );

    logic [1:0]          state_reg,    state_next;
    logic [ENERGY_W-1:0] snapshot_reg, snapshot_next;
    logic [FREQ_W-1:0]   req_freq_reg, req_freq_next;
    logic [BUDGET_W-1:0] energy_reg,   energy_next;
    logic                over_reg,     over_next;

    // Modulo-2^64 difference makes accumulator wrap transparent
    logic [ENERGY_W-1:0] delta;
    logic                over_cond;
    logic                under_cond;
    assign delta      = total_energy_pj - snapshot_reg;
    assign over_cond  = delta > {{(ENERGY_W-BUDGET_W){1'b0}}, budget_pj};
    assign under_cond = delta < {{(ENERGY_W-BUDGET_W+1){1'b0}}, budget_pj[BUDGET_W-1:1]};

    // Candidate step-down / step-up targets, clamped to [MIN, MAX]
    logic [FREQ_W:0] cur17;
    logic [FREQ_W:0] up_sum;
    logic [FREQ_W:0] dn_freq;
    logic [FREQ_W:0] up_freq;
    freq_req_t       dn_req;
    freq_req_t       up_req;

    assign cur17   = {1'b0, current_freq_mhz};
    assign up_sum  = cur17 + STEP17;
    assign dn_freq = (cur17 >= MIN17 + STEP17) ? (cur17 - STEP17) : MIN17;
    assign up_freq = (up_sum > MAX17) ? MAX17 : up_sum;

    // A zero frequency reading is treated as "not running": never request
    assign dn_req.go   = over_cond & (cur17 > MIN17) & (current_freq_mhz != '0);
    assign dn_req.freq = dn_freq[FREQ_W-1:0];
    assign up_req.go   = under_cond & (cur17 < MAX17) & (current_freq_mhz != '0);
    assign up_req.freq = up_freq[FREQ_W-1:0];

    always_comb begin
        state_next    = state_reg;
        snapshot_next = snapshot_reg;
        req_freq_next = req_freq_reg;
        energy_next   = energy_reg;
        over_next     = over_reg;

        // Every window end refreshes the energy outputs, whatever the state
        if (enable && window_end) begin
            snapshot_next = total_energy_pj;
            energy_next   = sat_energy(delta);
            over_next     = over_cond;
        end

        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        snapshot_next = total_energy_pj;
                        state_next    = ST_MONITOR;
                    end
                end
                ST_MONITOR: begin
                    if (window_end) begin
                        if (dn_req.go) begin
                            req_freq_next = dn_req.freq;
                            state_next    = ST_REQ;
                        end else if (up_req.go) begin
                            req_freq_next = up_req.freq;
                            state_next    = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // A window end coinciding with acceptance is consumed
                    // here, so HOLD waits for the following one.
                    if (req_ready) begin
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (window_end) begin
                        state_next = ST_MONITOR;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            snapshot_reg <= '0;
            req_freq_reg <= '0;
            energy_reg   <= '0;
            over_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            snapshot_reg <= snapshot_next;
            req_freq_reg <= req_freq_next;
            energy_reg   <= energy_next;
            over_reg     <= over_next;
        end
    end

    assign req_valid        = (state_reg == ST_REQ);
    assign req_freq_mhz     = req_freq_reg;
    assign window_energy_pj = energy_reg;
    assign over_budget      = over_reg;
    assign gov_state        = state_reg;

endmodule

// File: tb/tb_energy_budget_governor.sv
// ---------------------------------------------------------------------------
// tb_energy_budget_governor
// Directed scenarios for the energy budget governor with a 16-cycle window
// and a 1000 pJ budget. Each step pushes its expected outputs to a queue
// before driving the stimulus, then pops and compares once the DUT has
// produced the corresponding result.
// ---------------------------------------------------------------------------
module tb_energy_budget_governor;

    localparam int W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MON  = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [63:0] total_energy_pj;
    logic [31:0] budget_pj;
    logic [15:0] current_freq_mhz;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_freq_mhz;
    logic [31:0] window_energy_pj;
    logic        over_budget;
    logic [1:0]  gov_state;

    logic [63:0] inc;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [1:0]  st;
        logic        valid;
        logic        chk_freq;
        logic [15:0] freq;
        logic [31:0] energy;
        logic        over;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    energy_budget_governor #(
        .WINDOW_CYCLES (W),
        .FREQ_STEP_MHZ (100),
        .FREQ_MIN_MHZ  (100),
        .FREQ_MAX_MHZ  (1000)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .total_energy_pj  (total_energy_pj),
        .budget_pj        (budget_pj),
        .current_freq_mhz (current_freq_mhz),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_freq_mhz     (req_freq_mhz),
        .window_energy_pj (window_energy_pj),
        .over_budget      (over_budget),
        .gov_state        (gov_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the energy accumulator, then let one rising edge pass and
    // settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        total_energy_pj = total_energy_pj + inc;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic valid,
                        input logic chk_freq, input logic [15:0] freq,
                        input logic [31:0] energy, input logic over);
        exp_t e;
        e.st       = st;
        e.valid    = valid;
        e.chk_freq = chk_freq;
        e.freq     = freq;
        e.energy   = energy;
        e.over     = over;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic cmp(input string name, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
        end
    endtask

    task automatic check();
        exp_t  e;
        string tag;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            cmp({tag, ".gov_state"}, 64'(gov_state), 64'(e.st));
            cmp({tag, ".req_valid"}, 64'(req_valid), 64'(e.valid));
            if (e.chk_freq) cmp({tag, ".req_freq"}, 64'(req_freq_mhz), 64'(e.freq));
            cmp({tag, ".window_energy"}, 64'(window_energy_pj), 64'(e.energy));
            cmp({tag, ".over_budget"}, 64'(over_budget), 64'(e.over));
            $display("txn %-16s state=%0d valid=%0b freq=%0d energy=0x%0h over=%0b",
                     tag, gov_state, req_valid, req_freq_mhz, window_energy_pj, over_budget);
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset_n          = 1'b0;
        enable           = 1'b0;
        req_ready        = 1'b0;
        budget_pj        = 32'd1000;
        current_freq_mhz = 16'd500;
        total_energy_pj  = 64'd0;
        inc              = 64'd0;

        // Reset state
        push("reset", S_IDLE, 1'b0, 1'b1, 16'd0, 32'd0, 1'b0);
        ticks(2);
        check();
        reset_n = 1'b1;
        tick();

        // Over budget: 100/cycle -> 1600 per window, step 500 -> 400
        inc             = 64'd100;
        total_energy_pj = 64'd1000;
        enable          = 1'b1;
        push("over_w1", S_REQ, 1'b1, 1'b1, 16'd400, 32'd1600, 1'b1);
        ticks(W + 1);
        check();
        push("over_wait", S_REQ, 1'b1, 1'b1, 16'd400, 32'd1600, 1'b1);
        ticks(5);
        check();
        req_ready = 1'b1;
        push("over_hs", S_HOLD, 1'b0, 1'b1, 16'd400, 32'd1600, 1'b1);
        tick();
        req_ready = 1'b0;
        check();
        push("hold_wait", S_HOLD, 1'b0, 1'b1, 16'd400, 32'd1600, 1'b1);
        ticks(9);
        check();
        push("hold_done", S_MON, 1'b0, 1'b1, 16'd400, 32'd1600, 1'b1);
        tick();
        check();

        // Under budget at the frequency ceiling: no request
        inc              = 64'd20;
        current_freq_mhz = 16'd1000;
        push("under_fmax", S_MON, 1'b0, 1'b1, 16'd400, 32'd320, 1'b0);
        ticks(W);
        check();

        // Under budget at 500: step up to 600
        current_freq_mhz = 16'd500;
        push("under_req", S_REQ, 1'b1, 1'b1, 16'd600, 32'd320, 1'b0);
        ticks(W);
        check();

        // Abort from REQ without acceptance
        enable = 1'b0;
        push("abort", S_IDLE, 1'b0, 1'b0, 16'd0, 32'd320, 1'b0);
        tick();
        check();
        push("idle_hold", S_IDLE, 1'b0, 1'b0, 16'd0, 32'd320, 1'b0);
        ticks(3);
        check();

        // Accumulator wrap with a fresh snapshot taken on re-enable
        current_freq_mhz = 16'd1000;
        inc              = 64'd31;
        total_energy_pj  = 64'hFFFF_FFFF_FFFF_FF00 - 64'd31;
        enable           = 1'b1;
        push("wrap", S_MON, 1'b0, 1'b0, 16'd0, 32'h0000_01F0, 1'b0);
        ticks(W + 1);
        check();

        // Delta beyond 32 bits saturates
        inc              = 64'h0000_0000_1000_0001;
        current_freq_mhz = 16'd500;
        push("saturate", S_REQ, 1'b1, 1'b1, 16'd400, 32'hFFFF_FFFF, 1'b1);
        ticks(W);
        check();

        // Asynchronous reset between clock edges while in REQ
        #2;
        reset_n = 1'b0;
        push("async_rst", S_IDLE, 1'b0, 1'b1, 16'd0, 32'd0, 1'b0);
        #1;
        check();
        enable = 1'b0;
        tick();
        reset_n = 1'b1;

        // Zero frequency reading never requests
        inc              = 64'd20;
        current_freq_mhz = 16'd0;
        enable           = 1'b1;
        push("freq_zero", S_MON, 1'b0, 1'b1, 16'd0, 32'd320, 1'b0);
        ticks(W + 1);
        check();

        // Handshake landing on a window end does not count toward HOLD
        inc              = 64'd100;
        current_freq_mhz = 16'd500;
        push("w_req", S_REQ, 1'b1, 1'b1, 16'd400, 32'd1600, 1'b1);
        ticks(W);
        check();
        inc = 64'd90;
        push("req_pre_wend", S_REQ, 1'b1, 1'b1, 16'd400, 32'd1600, 1'b1);
        ticks(W - 1);
        check();
        req_ready = 1'b1;
        push("hs_at_wend", S_HOLD, 1'b0, 1'b1, 16'd400, 32'd1440, 1'b1);
        tick();
        req_ready = 1'b0;
        check();
        push("hold_skip", S_HOLD, 1'b0, 1'b1, 16'd400, 32'd1440, 1'b1);
        ticks(W - 1);
        check();
        push("hold_exit", S_MON, 1'b0, 1'b1, 16'd400, 32'd1440, 1'b1);
        tick();
        check();

        // Step-down clamps at the minimum: 150 -> 100
        current_freq_mhz = 16'd150;
        push("clamp_min", S_REQ, 1'b1, 1'b1, 16'd100, 32'd1440, 1'b1);
        ticks(W);
        check();

        // Step-up clamps at the maximum: 950 -> 1000
        enable = 1'b0;
        tick();
        current_freq_mhz = 16'd950;
        inc              = 64'd20;
        enable           = 1'b1;
        push("clamp_max", S_REQ, 1'b1, 1'b1, 16'd1000, 32'd320, 1'b0);
        ticks(W + 1);
        check();

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
